// File: rtl/sprite_pipeline_display_controller.sv
// Pipelined character sprite renderer for the VGA path.
// Maps char-box pixel coordinates to an external synchronous sprite ROM address (mirror plus
// integer down-scale), looks the returned colour index up in a writable palette and composites
// it over the background. Sprite-ID changes are debounced on frame boundaries and a frame-counted
// flash mode replaces opaque pixels with a fixed colour.
// Ports:
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   frame_start             1-cycle pulse before the first active pixel of a frame
//   char_id                 requested sprite
//   char_face               2'b01 native orientation, anything else mirrored
//   char_x_rom, char_y_rom  pixel offset inside the char box
//   char_on                 pixel lies inside the char box
//   background_rgb          colour behind the character
//   flash_en                enable flash mode
//   pal_we, pal_addr, pal_data  palette write port
//   rom_addr / rom_data     sprite ROM interface (data valid one cycle after address)
//   active_id               sprite currently rendered
//   rgb                     registered output pixel, three cycles after the inputs
module sprite_pipeline_display_controller #(
  parameter int unsigned             PIXEL_WIDTH    = 12,
  parameter int unsigned             SCREEN_WIDTH   = 10,
  parameter int unsigned             CHAR_WIDTH_X   = 42,
  parameter int unsigned             CHAR_WIDTH_Y   = 50,
  parameter int unsigned             SCALE_SHIFT    = 1,
  parameter int unsigned             SPRITE_NUM     = 7,
  parameter int unsigned             ID_WIDTH       = 3,
  parameter int unsigned             COLOR_WIDTH    = 4,
  parameter int unsigned             COLOR_NUM      = 12,
  parameter int unsigned             TRANSPARENT_ID = 11,
  parameter int unsigned             ADDR_WIDTH     = 12,
  parameter int unsigned             HOLD_FRAMES    = 2,
  parameter int unsigned             FLASH_PERIOD   = 8,
  parameter logic [PIXEL_WIDTH-1:0]  FLASH_RGB      = 12'hF00
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    frame_start,
  input  logic [ID_WIDTH-1:0]     char_id,
  input  logic signed [1:0]       char_face,
  input  logic [SCREEN_WIDTH-1:0] char_x_rom,
  input  logic [SCREEN_WIDTH-1:0] char_y_rom,
  input  logic                    char_on,
  input  logic [PIXEL_WIDTH-1:0]  background_rgb,
  input  logic                    flash_en,
  input  logic                    pal_we,
  input  logic [COLOR_WIDTH-1:0]  pal_addr,
  input  logic [PIXEL_WIDTH-1:0]  pal_data,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [COLOR_WIDTH-1:0]  rom_data,
  output logic [ID_WIDTH-1:0]     active_id,
  output logic [PIXEL_WIDTH-1:0]  rgb
);

  localparam int unsigned SPR_W    = CHAR_WIDTH_X >> SCALE_SHIFT;
  localparam int unsigned SPR_H    = CHAR_WIDTH_Y >> SCALE_SHIFT;
  localparam int unsigned SPR_SIZE = SPR_W * SPR_H;
  localparam int unsigned CALC_W   = ADDR_WIDTH + 2;
  localparam int unsigned CNT_W    = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned FL_W     = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
  localparam logic [PIXEL_WIDTH-1:0] RESET_RGB = {PIXEL_WIDTH{1'b1}};

  function automatic logic [PIXEL_WIDTH-1:0] pal_default(input int unsigned idx);
    logic [11:0] c;
    case (idx)
      0:       c = 12'hACF;
      1:       c = 12'h7AF;
      2:       c = 12'h000;
      3:       c = 12'h00F;
      4:       c = 12'h008;
      5:       c = 12'hF90;
      6:       c = 12'hA50;
      7:       c = 12'h420;
      8:       c = 12'h0CF;
      9:       c = 12'h13A;
      10:      c = 12'h027;
      default: c = 12'hFFF;
    endcase
    return PIXEL_WIDTH'(c);
  endfunction

  // Pipeline registers: stage 1 sits beside rom_addr, stage 2 beside rom_data.
  logic                   on1_q, on2_q;
  logic [PIXEL_WIDTH-1:0] bg1_q, bg2_q;
  logic [PIXEL_WIDTH-1:0] palette_q [COLOR_NUM];

  logic [ID_WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]    stable_q, stable_d;
  logic [ID_WIDTH-1:0] active_d;
  logic [FL_W-1:0]     flash_cnt_q, flash_cnt_d;
  logic                phase_q, phase_d;

  logic                    in_box;
  logic [SCREEN_WIDTH-1:0] x_mir, sx, sy;
  logic [CALC_W-1:0]       addr_calc;
  logic [PIXEL_WIDTH-1:0]  rgb_d;

  // Address generation. Mirroring is only used when x is inside the box, so the subtraction
  // never wraps for pixels that reach the ROM.
  always_comb begin
    in_box    = (32'(char_x_rom) < CHAR_WIDTH_X) && (32'(char_y_rom) < CHAR_WIDTH_Y);
    x_mir     = (char_face == 2'sb01) ? char_x_rom
                                      : SCREEN_WIDTH'(CHAR_WIDTH_X - 1) - char_x_rom;
    sx        = x_mir >> SCALE_SHIFT;
    sy        = char_y_rom >> SCALE_SHIFT;
    addr_calc = CALC_W'(active_id) * CALC_W'(SPR_SIZE) + CALC_W'(sy) * CALC_W'(SPR_W)
              + CALC_W'(sx);
  end

  // Sprite-ID debounce; only frame_start cycles touch it so the ID is frame-stable.
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    active_d = active_id;
    if (frame_start) begin
      if (32'(char_id) >= SPRITE_NUM) begin
        stable_d = '0;
      end else if (char_id != cand_q) begin
        cand_d   = char_id;
        stable_d = CNT_W'(1);
      end else if (32'(stable_q) < HOLD_FRAMES) begin
        stable_d = stable_q + CNT_W'(1);
      end
      if (32'(stable_d) == HOLD_FRAMES) active_d = cand_d;
    end
  end

  // Flash phase; dropping flash_en clears it without waiting for a frame boundary.
  always_comb begin
    flash_cnt_d = flash_cnt_q;
    phase_d     = phase_q;
    if (!flash_en) begin
      flash_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (frame_start) begin
      if (32'(flash_cnt_q) == FLASH_PERIOD - 1) begin
        flash_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        flash_cnt_d = flash_cnt_q + FL_W'(1);
      end
    end
  end

  // Colour stage; palette is read before any same-edge write lands.
  always_comb begin
    rgb_d = bg2_q;
    if (on2_q && (32'(rom_data) != TRANSPARENT_ID) && (32'(rom_data) < COLOR_NUM)) begin
      rgb_d = phase_q ? FLASH_RGB : palette_q[rom_data];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rom_addr    <= '0;
      on1_q       <= 1'b0;
      on2_q       <= 1'b0;
      bg1_q       <= RESET_RGB;
      bg2_q       <= RESET_RGB;
      rgb         <= RESET_RGB;
      cand_q      <= '0;
      stable_q    <= '0;
      active_id   <= '0;
      flash_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      if (in_box) rom_addr <= addr_calc[ADDR_WIDTH-1:0];
      on1_q       <= char_on & in_box;
      on2_q       <= on1_q;
      bg1_q       <= background_rgb;
      bg2_q       <= bg1_q;
      rgb         <= rgb_d;
      cand_q      <= cand_d;
      stable_q    <= stable_d;
      active_id   <= active_d;
      flash_cnt_q <= flash_cnt_d;
      phase_q     <= phase_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < COLOR_NUM; i++) palette_q[i] <= pal_default(i);
    end else if (pal_we && (32'(pal_addr) < COLOR_NUM)) begin
      palette_q[pal_addr] <= pal_data;
    end
  end

endmodule
